// File: rtl/csa_wide_add_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : csa_wide_add_seq_if
// Brief    : Operand stream (A/B words) and result stream for csa_wide_add_seq.
// Revision : 1.0
// ============================================================================
interface csa_wide_add_seq_if;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] a_word;
    logic [31:0] b_word;
    logic        sum_valid;
    logic        sum_ready;
    logic [31:0] sum_word;
    logic        sum_last;

    // master: operand producer and result consumer
    modport master (
        output op_valid, a_word, b_word, sum_ready,
        input  op_ready, sum_valid, sum_word, sum_last
    );

    // slave: the wide-add sequencer
    modport slave (
        input  op_valid, a_word, b_word, sum_ready,
        output op_ready, sum_valid, sum_word, sum_last
    );
endinterface
`default_nettype wire

// File: rtl/csa_wide_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : csa_wide_add_seq
// Brief    : Runs one 32-bit carry-skip adder over WORDS words (LS first) to
//            build a WORDS*32-bit add, carrying between words in a register.
// Revision : 1.0
// ============================================================================
module csa_wide_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic                i_cin,
    input  logic                i_abort,
    csa_wide_add_seq_if.slave   bus,
    output logic                o_cout,
    output logic                o_busy,
    output logic                o_done
);

    localparam int              c_CW   = $clog2(WORDS + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WORDS - 1);
    localparam int              c_BLK  = 4;
    localparam int              c_NBLK = 32 / c_BLK;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_CW-1:0]   r_count;
    logic              r_carry;
    logic              r_sum_valid;
    logic [31:0]       r_sum_word;
    logic              r_sum_last;
    logic              r_cout;

    logic              w_op_ready;
    logic              w_accept;
    logic              w_abort;
    logic              w_out_free;
    logic              w_start;
    logic [31:0]       w_sum;
    logic              w_csa_cout;

    // ------------------------------------------------------------------
    // Carry-skip adder: 4-bit ripple blocks, block carry bypasses the
    // ripple chain whenever every bit of the block propagates.
    // ------------------------------------------------------------------
    logic [c_NBLK:0]   w_blk_c;
    assign w_blk_c[0] = r_carry;

    for (genvar gb = 0; gb < c_NBLK; gb++) begin : g_blk
        logic [c_BLK:0]   w_rc;
        logic [c_BLK-1:0] w_p;
        assign w_rc[0] = w_blk_c[gb];
        for (genvar gi = 0; gi < c_BLK; gi++) begin : g_bit
            assign w_p[gi] = bus.a_word[c_BLK*gb+gi] ^ bus.b_word[c_BLK*gb+gi];
            assign w_sum[c_BLK*gb+gi] = w_p[gi] ^ w_rc[gi];
            assign w_rc[gi+1] = (bus.a_word[c_BLK*gb+gi] & bus.b_word[c_BLK*gb+gi])
                              | (w_p[gi] & w_rc[gi]);
        end
        assign w_blk_c[gb+1] = (&w_p) ? w_blk_c[gb] : w_rc[c_BLK];
    end

    assign w_csa_cout = w_blk_c[c_NBLK];

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    assign w_op_ready = (r_state == S_RUN) && (!r_sum_valid || bus.sum_ready);
    assign w_abort    = i_abort && ((r_state == S_RUN) || (r_state == S_DRAIN));
    assign w_accept   = bus.op_valid && w_op_ready && !w_abort;
    assign w_out_free = !r_sum_valid || bus.sum_ready;
    assign w_start    = (r_state == S_IDLE) && i_start;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_abort)
                    w_state_nxt = S_IDLE;
                else if (w_accept && (r_count == c_LAST))
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_abort)
                    w_state_nxt = S_IDLE;
                else if (w_out_free)
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: inter-word carry, word count, one-entry output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_carry     <= 1'b0;
            r_sum_valid <= 1'b0;
            r_sum_word  <= 32'h0;
            r_sum_last  <= 1'b0;
            r_cout      <= 1'b0;
        end else if (w_start) begin
            r_carry <= i_cin;
            r_count <= '0;
            r_cout  <= 1'b0;
        end else if (w_abort) begin
            r_sum_valid <= 1'b0;
            r_carry     <= 1'b0;
            r_count     <= '0;
        end else begin
            if (w_accept) begin
                r_sum_word  <= w_sum;
                r_sum_valid <= 1'b1;
                r_sum_last  <= (r_count == c_LAST);
                r_carry     <= w_csa_cout;
                r_count     <= r_count + 1'b1;
            end else if (bus.sum_ready) begin
                r_sum_valid <= 1'b0;
            end
            // Final carry is published as the last word leaves the register
            if ((r_state == S_DRAIN) && w_out_free) begin
                r_cout <= r_carry;
            end
        end
    end

    assign bus.op_ready  = w_op_ready;
    assign bus.sum_valid = r_sum_valid;
    assign bus.sum_word  = r_sum_word;
    assign bus.sum_last  = r_sum_last;
    assign o_cout        = r_cout;
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_csa_wide_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_csa_wide_add_seq
// Brief    : Self-checking bench; wide sums compared to plain 129-bit addition.
// Revision : 1.0
// ============================================================================
module tb_csa_wide_add_seq;

    localparam int WORDS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start, cin, abort, cout, busy, done;
    logic start1, cin1, abort1, cout1, busy1, done1;

    csa_wide_add_seq_if bus ();
    csa_wide_add_seq_if bus1 ();

    csa_wide_add_seq #(.WORDS(WORDS)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_cin(cin), .i_abort(abort),
        .bus(bus.slave), .o_cout(cout), .o_busy(busy), .o_done(done)
    );

    csa_wide_add_seq #(.WORDS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_start(start1), .i_cin(cin1), .i_abort(abort1),
        .bus(bus1.slave), .o_cout(cout1), .o_busy(busy1), .o_done(done1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [128:0] ref_add(input logic [127:0] a, input logic [127:0] b,
                                             input logic ci);
        return {1'b0, a} + {1'b0, b} + {128'd0, ci};
    endfunction

    // mode 0: always valid/ready, 1: random valid/ready, 2: 3-cycle stall after first result
    task automatic run_op(input logic [127:0] a, input logic [127:0] b, input logic ci,
                          input int mode, input bit poke, input int abort_at);
        logic [128:0] exp_r;
        logic [31:0]  held;
        int widx, ridx, cyc, last_acc, first_res, last_res, done_cyc, stall;
        bit fin, aborted, did_stall;
        exp_r = ref_add(a, b, ci);
        widx = 0; ridx = 0; cyc = 0; last_acc = 0; first_res = 0; last_res = 0;
        done_cyc = 0; stall = 0; fin = 0; aborted = 0; did_stall = 0; held = 32'h0;
        @(negedge clk);
        start = 1'b1; cin = ci;
        @(negedge clk);
        start = poke; cin = 1'b0;
        chk("busy_run", 32'(busy), 32'd1);
        while (!fin) begin
            if (mode == 2 && !did_stall && bus.sum_valid) begin
                did_stall = 1; stall = 3; held = bus.sum_word;
            end
            bus.op_valid  = (widx < WORDS) && (mode != 1 || $urandom_range(0, 2) != 0);
            bus.a_word    = (widx < WORDS) ? a[32*widx +: 32] : 32'h0;
            bus.b_word    = (widx < WORDS) ? b[32*widx +: 32] : 32'h0;
            bus.sum_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : (stall == 0);
            abort         = (abort_at >= 0) && (widx == abort_at);
            #1;
            if (abort) begin
                aborted = 1; fin = 1;
            end else begin
                if (stall > 0) begin
                    chk("stall_op_ready", 32'(bus.op_ready), 32'd0);
                    chk("stall_hold", bus.sum_word, held);
                    stall--;
                end
                if (bus.op_valid && bus.op_ready) begin
                    widx++; last_acc = cyc;
                end
                if (bus.sum_valid && bus.sum_ready) begin
                    if (ridx < WORDS) begin
                        chk("sum_word", bus.sum_word, exp_r[32*ridx +: 32]);
                        chk("sum_last", 32'(bus.sum_last), 32'(ridx == WORDS - 1));
                    end else begin
                        chk("extra_word", 32'(ridx), 32'(WORDS - 1));
                    end
                    if (ridx == 0) first_res = cyc;
                    last_res = cyc;
                    ridx++;
                end
                if (done) begin
                    chk("cout", 32'(cout), 32'(exp_r[128]));
                    chk("words_out", 32'(ridx), 32'(WORDS));
                    done_cyc = cyc; fin = 1;
                end else if (poke) begin
                    chk("busy_held", 32'(busy), 32'd1);
                end
            end
            cyc++;
            if (!fin && cyc >= 300) begin
                chk("timeout_words", 32'(ridx), 32'(WORDS));
                fin = 1;
            end
            if (!fin) @(negedge clk);
        end
        bus.op_valid = 1'b0;
        @(negedge clk);
        abort = 1'b0; start = 1'b0; bus.sum_ready = 1'b1;
        #1;
        if (aborted) begin
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_sum_valid", 32'(bus.sum_valid), 32'd0);
            chk("abort_done", 32'(done), 32'd0);
            chk("abort_cout", 32'(cout), 32'd0);
        end else begin
            if (mode == 0) begin
                chk("done_latency", 32'(done_cyc - last_acc), 32'd2);
                chk("result_span", 32'(last_res - first_res), 32'(WORDS - 1));
            end
            chk("done_single", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("cout_hold", 32'(cout), 32'(exp_r[128]));
        end
    endtask

    initial begin
        logic [127:0] ra, rb;
        logic [32:0]  e1;
        int nres;
        bit got, acc;
        start = 0; cin = 0; abort = 0; start1 = 0; cin1 = 0; abort1 = 0;
        bus.op_valid = 0; bus.a_word = 0; bus.b_word = 0; bus.sum_ready = 0;
        bus1.op_valid = 0; bus1.a_word = 0; bus1.b_word = 0; bus1.sum_ready = 0;

        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_op_ready", 32'(bus.op_ready), 32'd0);
        chk("rst_sum_valid", 32'(bus.sum_valid), 32'd0);
        chk("rst_sum_word", bus.sum_word, 32'h0);
        chk("rst_sum_last", 32'(bus.sum_last), 32'd0);
        chk("rst1_busy", 32'(busy1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.sum_ready = 1'b1;

        // all-ones plus carry-in ripples through every word
        run_op({4{32'hFFFFFFFF}}, 128'h0, 1'b1, 0, 0, -1);
        // mixed words, LS first: 8, FFFFFFFF, 0, 1
        run_op(128'h00000001_00000000_FFFFFFFF_00000005, 128'h3, 1'b0, 0, 0, -1);
        // same operands under consumer backpressure
        run_op(128'h00000001_00000000_FFFFFFFF_00000005, 128'h3, 1'b0, 2, 0, -1);
        // start held high through RUN/DRAIN/DONE
        run_op(128'h89ABCDEF_01234567_DEADBEEF_CAFEF00D, 128'h76543210_FEDCBA98_21524110_35010FF3,
               1'b1, 0, 1, -1);
        // abort on the third word, then a clean restart
        run_op({4{32'h12345678}}, {4{32'h11111111}}, 1'b1, 0, 0, 2);
        run_op({4{32'h1}}, {4{32'h1}}, 1'b0, 0, 0, -1);

        for (int i = 0; i < 6; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            run_op(ra, rb, 1'($urandom_range(0, 1)), 1, 0, -1);
        end
        run_op({4{32'hFFFFFFFF}}, {4{32'hFFFFFFFF}}, 1'b1, 1, 0, -1);

        // asynchronous reset in the middle of a run
        run_op({4{32'hFFFFFFFF}}, 128'h0, 1'b1, 0, 0, -1);
        @(negedge clk);
        start = 1'b1; cin = 1'b1;
        @(negedge clk);
        start = 1'b0; cin = 1'b0;
        bus.op_valid = 1'b1; bus.a_word = 32'h00001234; bus.b_word = 32'h00000100;
        bus.sum_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_cout", 32'(cout), 32'd0);
        chk("arst_op_ready", 32'(bus.op_ready), 32'd0);
        chk("arst_sum_valid", 32'(bus.sum_valid), 32'd0);
        chk("arst_sum_word", bus.sum_word, 32'h0);
        chk("arst_sum_last", 32'(bus.sum_last), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.op_valid = 1'b0;
        run_op(128'h00000001_00000000_FFFFFFFF_00000005, 128'h3, 1'b0, 0, 0, -1);

        // single-word instance
        e1 = {1'b0, 32'hFFFFFFFF} + {1'b0, 32'h1};
        @(negedge clk);
        start1 = 1'b1; cin1 = 1'b0;
        @(negedge clk);
        start1 = 1'b0;
        bus1.op_valid = 1'b1; bus1.a_word = 32'hFFFFFFFF; bus1.b_word = 32'h1;
        bus1.sum_ready = 1'b1;
        got = 0; nres = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            if (bus1.sum_valid) begin
                chk("w1_sum_word", bus1.sum_word, e1[31:0]);
                chk("w1_sum_last", 32'(bus1.sum_last), 32'd1);
                nres++;
            end
            if (done1) begin
                chk("w1_cout", 32'(cout1), 32'(e1[32]));
                got = 1;
            end
            acc = bus1.op_valid && bus1.op_ready;
            @(negedge clk);
            if (acc) bus1.op_valid = 1'b0;
        end
        chk("w1_done_seen", 32'(got), 32'd1);
        chk("w1_results", 32'(nres), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
